jk_excitation_driver: RTL and testbench

JK_EXCITATION_DRIVER -- requirements
Module: jk_excitation_driver

---
 rtl/jk_excitation_driver.sv | 111 +++++++++++
 tb/tb_jk_excitation_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop bank toward a commanded target value.
// It checks the fed-back Q after each drive and re-drives a limited number of times.
module jk_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 3,
  parameter bit USE_TOGGLE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] target, target_next;
  logic [RW-1:0]    retry;
  logic             accept;
  logic             match;
  logic             exhausted;
  logic [WIDTH-1:0] change;
  logic [WIDTH-1:0] j_next, k_next;

  assign accept    = cmd_valid && (state == IDLE);
  assign match     = (q_fb == target);
  assign exhausted = (retry == RW'(MAX_RETRY));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = CHECK;
      CHECK:   if (match || exhausted) state_next = IDLE;
               else                    state_next = DRIVE;
      default: state_next = IDLE;
    endcase
  end

  // The target is computed from the current Q at accept, so it is used on the same
  // edge that first enters DRIVE.
  always_comb begin
    target_next = target;
    if (accept) begin
      unique case (cmd_op)
        2'b00: target_next = cmd_data;
        2'b01: target_next = q_fb + {{(WIDTH-1){1'b0}}, 1'b1};
        2'b10: target_next = q_fb - {{(WIDTH-1){1'b0}}, 1'b1};
        2'b11: target_next = ~q_fb;
        default: target_next = target;
      endcase
    end
  end

  always_comb begin
    busy      = (state == DRIVE) || (state == CHECK);
    cmd_ready = (state == IDLE);
    change    = q_fb ^ target_next;
    j_next    = '0;
    k_next    = '0;
    if (state_next == DRIVE) begin
      if (USE_TOGGLE) begin
        j_next = change;
        k_next = change;
      end else begin
        j_next = change & target_next;
        k_next = change & ~target_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target <= '0;
      retry  <= '0;
      j      <= '0;
      k      <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      target <= target_next;
      j      <= j_next;
      k      <= k_next;
      done   <= (state == CHECK) && match;
      error  <= (state == CHECK) && !match && exhausted;
      if (accept)
        retry <= '0;
      else if ((state == CHECK) && !match && !exhausted)
        retry <= retry + RW'(1);
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (level and toggle excitation) each feed a behavioural
// JK bank, and outputs are checked #1 after each rising edge.
module tb_jk_excitation_driver;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, done, error;
  logic [7:0] q_fb, j, k;

  logic       t_valid = 1'b0;
  logic [1:0] t_op = 2'b00;
  logic       t_ready, t_busy, t_done, t_error;
  logic [7:0] t_q, t_j, t_k;

  logic       bank_load = 1'b0;
  logic [7:0] bank_val = 8'h00;
  logic       stuck = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  jk_excitation_driver #(.WIDTH(8), .MAX_RETRY(3), .USE_TOGGLE(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .q_fb(q_fb), .j(j), .k(k),
    .busy(busy), .done(done), .error(error));

  jk_excitation_driver #(.WIDTH(8), .MAX_RETRY(3), .USE_TOGGLE(1'b1)) dut_t (
    .clock(clock), .reset_n(reset_n), .cmd_valid(t_valid), .cmd_ready(t_ready),
    .cmd_op(t_op), .cmd_data(cmd_data), .q_fb(t_q), .j(t_j), .k(t_k),
    .busy(t_busy), .done(t_done), .error(t_error));

  // Behavioural JK banks: hold, set, reset or toggle per bit.
  function automatic logic [7:0] jk_next(input logic [7:0] q, jj, kk);
    for (int b = 0; b < 8; b++)
      jk_next[b] = (jj[b] & ~q[b]) | (~kk[b] & q[b]);
  endfunction

  always_ff @(posedge clock) begin
    if (bank_load)  q_fb <= bank_val;
    else if (!stuck) q_fb <= jk_next(q_fb, j, k);
  end

  always_ff @(posedge clock) begin
    if (bank_load) t_q <= bank_val;
    else           t_q <= jk_next(t_q, t_j, t_k);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    tick();
    bank_load = 1'b0;
  endtask

  initial begin
    // Reset state, with both banks preloaded during reset.
    bank_load = 1'b1;
    bank_val  = 8'h00;
    tick();
    tick();
    bank_load = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_jk", {j, k}, 16'h0000);
    check("rst_done_err", {done, error}, 2'b00);
    #2 reset_n = 1'b1;

    // Load 0xA5 from 0x00.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'hA5;
    tick();
    cmd_valid = 1'b0;
    check("load_drive_busy", {busy, cmd_ready}, 2'b10);
    check("load_drive_jk", {j, k}, 16'hA500);
    tick();
    check("load_check_jk", {j, k}, 16'h0000);
    check("load_check_q", q_fb, 8'hA5);
    check("load_check_done", done, 0);
    tick();
    check("load_done", {done, error, cmd_ready, busy}, 4'b1010);
    tick();
    check("load_done_pulse", done, 0);

    // Increment wraps 0xFF -> 0x00, then decrement wraps back.
    preload(8'hFF);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    tick();
    cmd_valid = 1'b0;
    check("inc_jk", {j, k}, 16'h00FF);
    tick();
    check("inc_q", q_fb, 8'h00);
    tick();
    check("inc_done", {done, error}, 2'b10);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick();
    cmd_valid = 1'b0;
    check("dec_jk", {j, k}, 16'hFF00);
    tick();
    check("dec_q", q_fb, 8'hFF);
    tick();
    check("dec_done", {done, error}, 2'b10);

    // Stuck bank: four drive attempts, then error eight edges after accept.
    preload(8'h00);
    stuck = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmd_valid = 1'b0;
      check($sformatf("stuck_drive%0d_jk", i), {busy, j, k}, {1'b1, 16'h0100});
      tick();
      check($sformatf("stuck_check%0d", i), {busy, j, done, error}, {1'b1, 8'h00, 2'b00});
    end
    tick();
    check("stuck_error", {error, done, cmd_ready}, 3'b101);
    tick();
    check("stuck_error_pulse", {error, done}, 2'b00);
    stuck = 1'b0;

    // Reset asserted during DRIVE aborts with no pulse.
    cmd_valid = 1'b1; cmd_data = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    check("abort_drive_jk", {j, k}, 16'h3C00);
    #2 reset_n = 1'b0;
    #1;
    check("abort_async", {j, k, busy, cmd_ready}, {16'h0000, 2'b01});
    tick();
    #2 reset_n = 1'b1;
    tick();
    check("abort_no_pulse", {done, error, busy}, 3'b000);
    tick();
    check("abort_no_pulse2", {done, error, q_fb}, {2'b00, 8'h00});
    cmd_valid = 1'b1; cmd_data = 8'h3C;
    tick();
    cmd_valid = 1'b0;
    check("reload_jk", {j, k}, 16'h3C00);
    tick();
    check("reload_q", q_fb, 8'h3C);
    tick();
    check("reload_done", {done, error}, 2'b10);

    // cmd_valid held high with changing data: second command taken in the done cycle.
    cmd_valid = 1'b1; cmd_data = 8'h11;
    tick();
    check("busy_first_jk", {j, k}, 16'h012C);
    cmd_data = 8'h77;
    tick();
    check("busy_q", q_fb, 8'h11);
    cmd_data = 8'h99;
    tick();
    check("busy_done", {done, cmd_ready, q_fb}, {2'b11, 8'h11});
    tick();
    cmd_valid = 1'b0;
    check("busy_second_jk", {busy, j, k}, {1'b1, 16'h8800});
    tick();
    check("busy_second_q", q_fb, 8'h99);
    tick();
    check("busy_second_done", {done, error}, 2'b10);

    // Toggle excitation: invert 0x0F.
    preload(8'h0F);
    t_valid = 1'b1; t_op = 2'b11;
    tick();
    t_valid = 1'b0;
    check("tog_jk", {t_j, t_k}, 16'hFFFF);
    tick();
    check("tog_q", t_q, 8'hF0);
    tick();
    check("tog_done", {t_done, t_error}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
